// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared state, digit-limit and digit-select definitions for the aclock time setter
package aclk_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EDIT_H1 = 3'd1;
  localparam logic [2:0] ST_EDIT_H0 = 3'd2;
  localparam logic [2:0] ST_EDIT_M1 = 3'd3;
  localparam logic [2:0] ST_EDIT_M0 = 3'd4;
  localparam logic [2:0] ST_LOAD    = 3'd5;

  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_20 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  typedef enum logic [1:0] {
    DIG_H1 = 2'd0,
    DIG_H0 = 2'd1,
    DIG_M1 = 2'd2,
    DIG_M0 = 2'd3
  } digit_sel_e;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  // Out-of-range digits collapse to 0, including hour units above 3 in the 20s.
  function automatic hhmm_t clamp_hhmm(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (r.h1 > H1_MAX) r.h1 = '0;
    if (r.h0 > H0_MAX) r.h0 = '0;
    if ((r.h1 == H1_MAX) && (r.h0 > H0_MAX_20)) r.h0 = '0;
    if (r.m1 > M1_MAX) r.m1 = '0;
    if (r.m0 > M0_MAX) r.m0 = '0;
    return r;
  endfunction

  function automatic hhmm_t inc_digit(input hhmm_t t, input digit_sel_e sel);
    hhmm_t r;
    r = t;
    case (sel)
      DIG_H1: begin
        r.h1 = (t.h1 >= H1_MAX) ? 2'd0 : t.h1 + 2'd1;
        if ((r.h1 == H1_MAX) && (r.h0 > H0_MAX_20)) r.h0 = '0;
      end
      DIG_H0: r.h0 = (t.h0 >= ((t.h1 == H1_MAX) ? H0_MAX_20 : H0_MAX)) ? 4'd0 : t.h0 + 4'd1;
      DIG_M1: r.m1 = (t.m1 >= M1_MAX) ? 4'd0 : t.m1 + 4'd1;
      default: r.m0 = (t.m0 >= M0_MAX) ? 4'd0 : t.m0 + 4'd1;
    endcase
    return r;
  endfunction

  function automatic digit_sel_e state_digit(input logic [2:0] st);
    case (st)
      ST_EDIT_H0: return DIG_H0;
      ST_EDIT_M1: return DIG_M1;
      ST_EDIT_M0: return DIG_M0;
      default:    return DIG_H1;
    endcase
  endfunction

  function automatic logic [2:0] next_edit(input logic [2:0] st);
    case (st)
      ST_EDIT_H1: return ST_EDIT_H0;
      ST_EDIT_H0: return ST_EDIT_M1;
      ST_EDIT_M1: return ST_EDIT_M0;
      ST_EDIT_M0: return ST_LOAD;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/aclk_btn_rep.sv
// rtl/aclk_btn_rep.sv - rising-edge press detector with optional hold-to-repeat events
module aclk_btn_rep #(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  localparam int CW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
  localparam logic [CW-1:0] FIRE = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] WRAP = CW'(REPEAT_DLY + REPEAT_PER - 1);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds how many cycles the button was already high before this one;
  // once past the initial delay it cycles FIRE..WRAP so FIRE recurs every period.
  always_comb begin
    prev_d = btn;
    cnt_d  = '0;
    if (btn) cnt_d = (cnt_q == WRAP) ? FIRE : cnt_q + CW'(1);
  end

  assign evt = btn && (!prev_q || (REPEAT_EN && (cnt_q == FIRE)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/aclk_time_setter.sv
// rtl/aclk_time_setter.sv - button-driven HH:MM digit editor issuing aclock time/alarm loads
module aclk_time_setter
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_PER  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_cancel,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       edit_active,
  output logic       edit_alarm,
  output logic [1:0] edit_digit
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic ev_time, ev_alarm, ev_inc, ev_next, ev_cancel, ev_press;

  aclk_btn_rep #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_rep_time   (.clk(clk), .reset(reset), .btn(btn_time),   .evt(ev_time));
  aclk_btn_rep #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_rep_alarm  (.clk(clk), .reset(reset), .btn(btn_alarm),  .evt(ev_alarm));
  aclk_btn_rep #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_rep_inc    (.clk(clk), .reset(reset), .btn(btn_inc),    .evt(ev_inc));
  aclk_btn_rep #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_rep_next   (.clk(clk), .reset(reset), .btn(btn_next),   .evt(ev_next));
  aclk_btn_rep #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_rep_cancel (.clk(clk), .reset(reset), .btn(btn_cancel), .evt(ev_cancel));

  assign ev_press = ev_time | ev_alarm | ev_inc | ev_next | ev_cancel;

  logic [2:0]      state_q, state_d;
  hhmm_t           dig_q, dig_d;
  hhmm_t           shadow_q, shadow_d;
  hhmm_t           hin_q, hin_d;
  logic            alarm_q, alarm_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
  logic            active_q, active_d;
  logic [1:0]      digit_q, digit_d;

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    alarm_d  = alarm_q;
    to_d     = to_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_time) begin
          dig_d   = clamp_hhmm({cur_H1, cur_H0, cur_M1, cur_M0});
          alarm_d = 1'b0;
          to_d    = '0;
          state_d = ST_EDIT_H1;
        end else if (ev_alarm) begin
          dig_d   = shadow_q;
          alarm_d = 1'b1;
          to_d    = '0;
          state_d = ST_EDIT_H1;
        end
      end
      ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
        if (ev_cancel)    state_d = ST_IDLE;
        else if (ev_next) state_d = next_edit(state_q);
        else if (ev_inc)  dig_d   = inc_digit(dig_q, state_digit(state_q));
        // Inactivity abort behaves exactly like cancel: no load, shadow untouched.
        if (ev_press)               to_d    = '0;
        else if (to_q == TO_LAST)   state_d = ST_IDLE;
        else                        to_d    = to_q + TO_W'(1);
      end
      ST_LOAD: begin
        if (alarm_q) shadow_d = dig_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    hin_d      = dig_q;
    ld_time_d  = (state_d == ST_LOAD) && !alarm_d;
    ld_alarm_d = (state_d == ST_LOAD) && alarm_d;
    active_d   = (state_d == ST_EDIT_H1) || (state_d == ST_EDIT_H0) ||
                 (state_d == ST_EDIT_M1) || (state_d == ST_EDIT_M0);
    digit_d    = active_d ? state_digit(state_d) : DIG_H1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dig_q      <= '0;
      shadow_q   <= '0;
      hin_q      <= '0;
      alarm_q    <= 1'b0;
      to_q       <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      active_q   <= 1'b0;
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      shadow_q   <= shadow_d;
      hin_q      <= hin_d;
      alarm_q    <= alarm_d;
      to_q       <= to_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      active_q   <= active_d;
      digit_q    <= digit_d;
    end
  end

  assign H_in1       = hin_q.h1;
  assign H_in0       = hin_q.h0;
  assign M_in1       = hin_q.m1;
  assign M_in0       = hin_q.m0;
  assign LD_time     = ld_time_q;
  assign LD_alarm    = ld_alarm_q;
  assign edit_active = active_q;
  assign edit_alarm  = alarm_q;
  assign edit_digit  = digit_q;

endmodule
